// File: rtl/oled_screen_arbiter.sv
// Round-robin arbiter that hands the OLED page driver to one of three screen
// requesters, runs the EN/FIN handshake, holds the page for a dwell time and acks.
module oled_screen_arbiter #(
   parameter int N_REQ          = 3,
   parameter int DWELL_CYCLES   = 100_000_000,
   parameter int TIMEOUT_CYCLES = 2_000_000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_REQ-1:0] REQ,
   output logic [N_REQ-1:0] GNT,
   output logic [N_REQ-1:0] ACK,
   output logic [1:0]       SEL,
   output logic             DISP_EN,
   input  logic             DISP_FIN,
   output logic             BUSY,
   output logic             TIMEOUT_ERR,
   output logic [2:0]       STATE_DBG
);

   localparam int DW = $clog2(DWELL_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GRANT   = 3'd1,
      DRIVE   = 3'd2,
      RELEASE = 3'd3,
      DWELL   = 3'd4,
      FINISH  = 3'd5
   } state_t;

   state_t           state_q;
   logic [N_REQ-1:0] gnt_q;
   logic [N_REQ-1:0] ack_q;
   logic [1:0]       sel_q;
   logic [1:0]       ptr_q;
   logic             en_q;
   logic             busy_q;
   logic             err_q;
   logic [DW-1:0]    dwell_q;
   logic [TW-1:0]    tmo_q;

   logic [N_REQ-1:0] rot_d;
   logic [1:0]       off_d;
   logic [2:0]       sum_d;
   logic [1:0]       win_d;
   logic [1:0]       ptr_d;
   logic             found_d;

   // rot_d[k] is the request at priority slot k counted from ptr_q
   always_comb begin
      case (ptr_q)
         2'd1:    rot_d = {REQ[0], REQ[2], REQ[1]};
         2'd2:    rot_d = {REQ[1], REQ[0], REQ[2]};
         default: rot_d = REQ;
      endcase
      found_d = |REQ;
      if (rot_d[0])      off_d = 2'd0;
      else if (rot_d[1]) off_d = 2'd1;
      else               off_d = 2'd2;
      sum_d = {1'b0, ptr_q} + {1'b0, off_d};
      win_d = (sum_d >= 3'd3) ? 2'(sum_d - 3'd3) : sum_d[1:0];
      ptr_d = (win_d == 2'd2) ? 2'd0 : win_d + 2'd1;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ack_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         dwell_q <= '0;
         tmo_q   <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q      <= GRANT;
                  gnt_q        <= '0;
                  gnt_q[win_d] <= 1'b1;
                  sel_q        <= win_d;
                  ptr_q        <= ptr_d;
                  busy_q       <= 1'b1;
               end
            end
            GRANT: begin
               state_q <= DRIVE;
               en_q    <= 1'b1;
               tmo_q   <= '0;
            end
            DRIVE: begin
               if (DISP_FIN) begin
                  state_q <= RELEASE;
                  en_q    <= 1'b0;
                  tmo_q   <= '0;
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= FINISH;
                  en_q    <= 1'b0;
                  err_q   <= 1'b1;
                  ack_q   <= gnt_q;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            RELEASE: begin
               if (!DISP_FIN) begin
                  if (DWELL_CYCLES == 0) begin
                     state_q <= FINISH;
                     ack_q   <= gnt_q;
                  end else begin
                     state_q <= DWELL;
                     dwell_q <= '0;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  state_q <= FINISH;
                  err_q   <= 1'b1;
                  ack_q   <= gnt_q;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            DWELL: begin
               if (dwell_q == DWELL_LAST) begin
                  state_q <= FINISH;
                  ack_q   <= gnt_q;
               end else begin
                  dwell_q <= dwell_q + 1'b1;
               end
            end
            FINISH: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               sel_q   <= '0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               gnt_q   <= '0;
               sel_q   <= '0;
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign GNT         = gnt_q;
   assign ACK         = ack_q;
   assign SEL         = sel_q;
   assign DISP_EN     = en_q;
   assign BUSY        = busy_q;
   assign TIMEOUT_ERR = err_q;
   assign STATE_DBG   = state_q;

endmodule

// File: doc/oled_screen_arbiter.md
OLED_SCREEN_ARBITER -- requirements
Module: oled_screen_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of screen requesters (fixed at 3 for this revision).
REQ-002 SHALL have parameter DWELL_CYCLES, default 100_000_000, minimum on-screen hold after a refresh completes, in clock cycles.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2_000_000, maximum wait for a display-driver handshake phase, in clock cycles.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port REQ, input, 3 bits: per-requester screen-refresh request, level.
REQ-007 SHALL have port GNT, output, 3 bits: one-hot grant, held for the whole service.
REQ-008 SHALL have port ACK, output, 3 bits: one-cycle completion pulse to the served requester.
REQ-009 SHALL have port SEL, output, 2 bits: index of the granted requester, steering the external Page0..Page3 mux.
REQ-010 SHALL have port DISP_EN, output, 1 bit: enable to the OLED page driver.
REQ-011 SHALL have port DISP_FIN, input, 1 bit: driver finish flag (high while the driver sits in Done).
REQ-012 SHALL have port BUSY, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port TIMEOUT_ERR, output, 1 bit: sticky handshake-timeout flag.

Function
REQ-014 SHALL implement states IDLE, GRANT, DRIVE, RELEASE, DWELL and FINISH.
REQ-015 In IDLE with any REQ bit high, SHALL pick a winner by round-robin starting from pointer PTR, then enter GRANT on the next cycle with GNT one-hot and SEL equal to the winner index.
REQ-016 PTR SHALL reset to 0 and, on every grant to index i, update to (i+1) mod 3.
REQ-017 GRANT SHALL last exactly one cycle, giving the page mux one settle cycle; DISP_EN SHALL then rise on entry to DRIVE, two cycles after REQ is first sampled in IDLE.
REQ-018 DRIVE SHALL hold DISP_EN high until DISP_FIN is sampled high, then enter RELEASE with DISP_EN low on the following cycle.
REQ-019 RELEASE SHALL hold DISP_EN low until DISP_FIN is sampled low, then enter DWELL.
REQ-020 DWELL SHALL count exactly DWELL_CYCLES cycles, then enter FINISH; when DWELL_CYCLES is 0, RELEASE SHALL go directly to FINISH.
REQ-021 FINISH SHALL last one cycle: the ACK bit of the granted index is high, GNT and SEL are cleared on exit, and the next state is IDLE.
REQ-022 GNT and SEL SHALL be latched at grant; deassertion of REQ by the granted requester after grant SHALL NOT abort service, and ACK SHALL still pulse.
REQ-023 A requester holding REQ through its own ACK SHALL be re-arbitrated normally in IDLE; it SHALL NOT be served again before other pending requesters, per PTR.
REQ-024 SHALL share one timeout counter across DRIVE and RELEASE, cleared on entry to each state; reaching TIMEOUT_CYCLES SHALL set TIMEOUT_ERR, force DISP_EN low and go straight to FINISH, skipping DWELL, with ACK still pulsed.
REQ-025 TIMEOUT_ERR SHALL remain set until reset.
REQ-026 Counters SHALL be sized by $clog2 of their parameter plus 1 and SHALL NOT wrap.
REQ-027 GNT and ACK SHALL never have more than one bit set, and ACK SHALL be nonzero only in FINISH.
REQ-028 DISP_EN SHALL be high only in DRIVE.

Reset
REQ-029 With RST low on a rising edge, the block SHALL enter IDLE, and GNT, ACK, SEL, DISP_EN, BUSY, TIMEOUT_ERR, PTR and both counters SHALL be 0.
REQ-030 Reset SHALL take effect from any state, including mid-DRIVE, with DISP_EN low on the cycle after the reset edge.

Verification (DWELL_CYCLES=4, TIMEOUT_CYCLES=20, driver model asserts FIN 5 cycles after EN and clears it 1 cycle after EN falls)
REQ-031 Single request: REQ=001 -> GNT=001 and SEL=0 at +1 cycle; DISP_EN high at +2; after the FIN handshake and 4 dwell cycles, ACK=001 for exactly one cycle; BUSY returns to 0.
REQ-032 Round-robin: REQ=111 held continuously -> grant order is 0,1,2,0, with exactly one ACK per service.
REQ-033 Requester drop: REQ=010 for one cycle only -> full service completes and ACK=010 pulses.
REQ-034 Timeout: driver never asserts FIN -> DISP_EN falls after 20 DRIVE cycles, TIMEOUT_ERR=1 and stays set, ACK pulses, DWELL is skipped.
REQ-035 Reset mid-DRIVE: RST low while DISP_EN=1 -> all outputs 0 next cycle, and the next REQ=100 is granted from PTR=0.
